// File: rtl/fifo_to_ram_writer.sv
// fifo_to_ram_writer: drains a normal-mode FIFO into consecutive RAM addresses, counting wrapped passes
module fifo_to_ram_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int START_ADDR = 0,
  parameter bit STOP_ON_WRAP = 1'b0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rearm,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty,
  output logic                  fifo_rdreq,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_wren,
  output logic                  wrap_pulse,
  output logic [7:0]            pass_count,
  output logic                  halted
);
  logic                  rd_valid_q, halt_q, halt_d, wrap_q, wrap_now;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] last_q;
  logic [7:0]            pass_q, pass_d;
  // Write the word popped last cycle; reset discards it, and a halting wrap blocks the same-cycle pop
  always_comb begin
    ram_wren = rd_valid_q & ~rst;
    wrap_now = ram_wren & (&wr_addr_q);
    halted = halt_q | (wrap_now & STOP_ON_WRAP);
    fifo_rdreq = enable & ~fifo_empty & ~halted & ~rst;
    ram_addr = wr_addr_q;
    ram_data_out = ram_wren ? fifo_data_in : last_q;
    wr_addr_d = ram_wren ? wr_addr_q + 1'b1 : wr_addr_q;
    pass_d = pass_q + {7'd0, wrap_now};
    halt_d = (wrap_now & STOP_ON_WRAP) | (halt_q & ~rearm);
    wrap_pulse = wrap_q;
    pass_count = pass_q;
  end
  // State registers; the address wraps to 0 by natural overflow, not back to START_ADDR
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      wr_addr_q <= ADDR_WIDTH'(START_ADDR);
      last_q <= '0;
      wrap_q <= 1'b0;
      pass_q <= '0;
      halt_q <= 1'b0;
    end else begin
      rd_valid_q <= fifo_rdreq;
      wr_addr_q <= wr_addr_d;
      last_q <= ram_data_out;
      wrap_q <= wrap_now;
      pass_q <= pass_d;
      halt_q <= halt_d;
    end
  end
endmodule
